// File: rtl/vector_alu_pipe_pkg.sv
// Opcodes, FSM states and AES S-box tables shared by the vector ALU pipe.
package vector_alu_pkg;

    typedef enum logic [3:0] {
        VALU_OP_XOR              = 4'b0000,
        VALU_OP_ROT              = 4'b0001,
        VALU_OP_AND              = 4'b0010,
        VALU_OP_OR               = 4'b0011,
        VALU_OP_ADD32            = 4'b0100,
        VALU_OP_AES_SUBBYTES     = 4'b1000,
        VALU_OP_AES_INV_SUBBYTES = 4'b1001
    } valu_op_e;

    typedef enum logic [1:0] {
        VALU_IDLE,
        VALU_SBOX,
        VALU_HOLD
    } valu_state_e;

    localparam logic [7:0] AES_SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] AES_SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/vector_alu_pipe_sbox_lane.sv
// One combinational AES S-box lane; inv selects the inverse table.
module aes_sbox_lane
    import vector_alu_pkg::*;
(
    input  logic [7:0] data,
    input  logic       inv,
    output logic [7:0] sub
);

    assign sub = inv ? AES_SBOX_INV[data] : AES_SBOX_FWD[data];

endmodule

// File: rtl/vector_alu_pipe.sv
// Handshaked vector ALU; S-box ops are built only with VALU_AES_EN defined
// and iterate over the vector SBOX_PAR bytes per cycle.
module vector_alu_pipe
    import vector_alu_pkg::*;
#(
    parameter int WIDTH    = 128,
    parameter int SBOX_PAR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    if (WIDTH < 32 || WIDTH % 32 != 0 || (WIDTH / 8) % SBOX_PAR != 0) begin : g_bad_cfg
        $error("vector_alu_pipe: unsupported WIDTH/SBOX_PAR");
    end

    valu_state_e      state_q;
    valu_state_e      state_d;
    logic [WIDTH-1:0] res_q;
    logic             ill_q;
    logic             accept;
    logic             is_sbox;
    logic             last_chunk;

    function automatic logic [WIDTH:0] alu_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [3:0]       ctl
    );
        logic [WIDTH-1:0] r;
        logic             ill;
        r   = '0;
        ill = 1'b0;
        case (ctl)
            VALU_OP_XOR: r = a ^ b;
            VALU_OP_ROT: r = WIDTH'({a, a} << b[SHW-1:0] >> WIDTH);
            VALU_OP_AND: r = a & b;
            VALU_OP_OR:  r = a | b;
            VALU_OP_ADD32: begin
                // Lanes are summed independently so carries stop at 32 bits.
                for (int l = 0; l < WIDTH / 32; l++) begin
                    r[l*32 +: 32] = a[l*32 +: 32] + b[l*32 +: 32];
                end
            end
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    assign in_ready  = (state_q == VALU_IDLE) ||
                       (state_q == VALU_HOLD && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == VALU_HOLD);
    assign result    = res_q;
    assign illegal   = ill_q;

`ifdef VALU_AES_EN
    localparam int N     = WIDTH / (8 * SBOX_PAR);
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK = 8 * SBOX_PAR;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] op_q;
    logic             inv_q;
    logic [CHUNK-1:0] chunk_in;
    logic [CHUNK-1:0] chunk_sub;

    assign is_sbox    = (alu_control == VALU_OP_AES_SUBBYTES) ||
                        (alu_control == VALU_OP_AES_INV_SUBBYTES);
    assign last_chunk = (cnt_q == LAST);
    assign busy       = (state_q == VALU_SBOX);
    assign chunk_in   = op_q[cnt_q*CHUNK +: CHUNK];

    for (genvar i = 0; i < SBOX_PAR; i++) begin : g_lane
        aes_sbox_lane u_lane (
            .data (chunk_in[i*8 +: 8]),
            .inv  (inv_q),
            .sub  (chunk_sub[i*8 +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            op_q  <= '0;
            inv_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            op_q  <= op1;
            inv_q <= alu_control[0];
        end else if (state_q == VALU_SBOX) begin
            cnt_q <= last_chunk ? '0 : cnt_q + CW'(1);
        end
    end
`else
    assign is_sbox    = 1'b0;
    assign last_chunk = 1'b1;
    assign busy       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VALU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            VALU_IDLE: begin
                if (accept) state_d = is_sbox ? VALU_SBOX : VALU_HOLD;
            end
            VALU_SBOX: begin
                if (last_chunk) state_d = VALU_HOLD;
            end
            VALU_HOLD: begin
                if (accept)         state_d = is_sbox ? VALU_SBOX : VALU_HOLD;
                else if (out_ready) state_d = VALU_IDLE;
            end
            default: state_d = VALU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            ill_q <= 1'b0;
        end else if (accept) begin
            if (is_sbox) begin
                res_q <= '0;
                ill_q <= 1'b0;
            end else begin
                {ill_q, res_q} <= alu_eval(op1, op2, alu_control);
            end
        end
`ifdef VALU_AES_EN
        else if (state_q == VALU_SBOX) begin
            res_q[cnt_q*CHUNK +: CHUNK] <= chunk_sub;
        end
`endif
    end

endmodule
